// File: rtl/ep2_port_demux_if.sv
// EP2 demux bus interface: the upstream byte stream (valid/ready) and the
// four-port write-FIFO side of ep2_port_demux, bundled as one port.
interface ep2_port_demux_if #(
    parameter int unsigned NUM_PORTS = 4
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           fifo_data;
    logic [NUM_PORTS-1:0] fifo_write;
    logic [NUM_PORTS-1:0] fifo_full;

    // Demux side: consumes the stream, drives the FIFO write strobes.
    modport slave (
        input  in_data, in_valid, fifo_full,
        output in_ready, fifo_data, fifo_write
    );

    // Environment side: produces the stream, models the FIFOs.
    modport master (
        output in_data, in_valid, fifo_full,
        input  in_ready, fifo_data, fifo_write
    );
endinterface

// File: rtl/ep2_port_demux.sv
// EP2 host-stream port demultiplexer.
// Parses packets of the form {header, LEN_HI, LEN_LO, N payload bytes} and
// steers each payload byte to the write FIFO named by header[1:0], keeping a
// wrapping per-port payload byte count for the memory arbitrator.
// Optional build macro DEMUX_TIMEOUT_EN: aborts a packet whose input has
// stalled (outside FIFO backpressure) for TIMEOUT_CYCLES cycles.
module ep2_port_demux #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter logic [3:0]  SYNC_NIBBLE = 4'hA,
    parameter int unsigned COUNT_WIDTH = 32
`ifdef DEMUX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    ep2_port_demux_if.slave                  bus,
    output logic [NUM_PORTS*COUNT_WIDTH-1:0] write_fifo_byte_counts,
    output logic                             pkt_active,
    output logic [1:0]                       cur_port,
    output logic [7:0]                       err_count,
    output logic                             err_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD
    } state_e;

    state_e               state_q, state_d;
    logic [15:0]          remaining_q, remaining_d;
    logic [1:0]           cur_port_q, cur_port_d;
    logic                 pkt_active_q, pkt_active_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 err_pulse_q, err_pulse_d;

    logic                 sel_full;
    logic                 in_ready;
    logic                 xfer;
    logic                 err_event;
    logic [15:0]          len_full;
    logic [NUM_PORTS-1:0] wr_vec;

`ifdef DEMUX_TIMEOUT_EN
    logic [15:0]          idle_cnt_q, idle_cnt_d;
`endif

    // Handshake and zero-latency FIFO path: only payload bytes are steered out.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no
        // path through the block leaves it unassigned and infers a latch.
        sel_full  = bus.fifo_full[cur_port_q];
        in_ready  = (state_q == ST_PAYLOAD) ? !sel_full : 1'b1;
        xfer      = bus.in_valid && in_ready;
        wr_vec    = '0;
        bus.fifo_data = 8'h00;
        if (state_q == ST_PAYLOAD) begin
            bus.fifo_data = bus.in_data;
            if (xfer) begin
                wr_vec = NUM_PORTS'(1) << cur_port_q;
            end
        end
        bus.in_ready   = in_ready;
        bus.fifo_write = wr_vec;
    end

    // Packet parser next-state: header check, length capture, payload countdown.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the updated value; clocked blocks use '<=' so all registers sample
        // the same pre-edge values.
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_port_d  = cur_port_q;
        err_event   = 1'b0;
        len_full    = {remaining_q[15:8], bus.in_data};
`ifdef DEMUX_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (bus.in_data[7:4] == SYNC_NIBBLE) begin
                        cur_port_d = bus.in_data[1:0];
                        state_d    = ST_LEN_HI;
                    end else begin
                        err_event  = 1'b1;
                    end
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    remaining_d = {bus.in_data, remaining_q[7:0]};
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    remaining_d = len_full;
                    state_d     = (len_full == 16'd0) ? ST_IDLE : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DEMUX_TIMEOUT_EN
        // Stall watchdog: FIFO backpressure is not the sender's fault, so it
        // neither advances nor clears the idle count.
        if (state_q == ST_IDLE || xfer) begin
            idle_cnt_d = 16'd0;
        end else if (!(state_q == ST_PAYLOAD && sel_full)) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
            if (idle_cnt_d == 16'(TIMEOUT_CYCLES)) begin
                idle_cnt_d  = 16'd0;
                state_d     = ST_IDLE;
                remaining_d = 16'd0;
                err_event   = 1'b1;
            end
        end
`endif

        pkt_active_d = (state_d != ST_IDLE);
        err_pulse_d  = err_event;
        err_count_d  = err_count_q;
        if (err_event && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Parser state and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every control register has an explicit async reset value; a
        // mid-packet reset must leave nothing of the old packet behind.
        if (!reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 16'd0;
            cur_port_q   <= 2'd0;
            pkt_active_q <= 1'b0;
            err_count_q  <= 8'd0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            cur_port_q   <= cur_port_d;
            pkt_active_q <= pkt_active_d;
            err_count_q  <= err_count_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

`ifdef DEMUX_TIMEOUT_EN
    // Idle-cycle counter for the stall watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= 16'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    // One wrapping payload byte counter per destination port.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [COUNT_WIDTH-1:0] cnt_q;

        // Count each byte written to this port's FIFO.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else if (wr_vec[p]) begin
                cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
        end

        assign write_fifo_byte_counts[p*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
    end

    assign pkt_active = pkt_active_q;
    assign cur_port   = cur_port_q;
    assign err_count  = err_count_q;
    assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_ep2_port_demux.sv
// Directed bench for ep2_port_demux: packet routing, empty packets, bad
// headers, FIFO backpressure, counter wrap, mid-packet reset and (when
// DEMUX_TIMEOUT_EN is defined) the stall abort.
module tb_ep2_port_demux;

    logic         clk;
    logic         reset;
    logic [127:0] counts;
    logic         pkt_active;
    logic [1:0]   cur_port;
    logic [7:0]   err_count;
    logic         err_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    ep2_port_demux_if #(.NUM_PORTS(4)) bus ();

`ifdef DEMUX_TIMEOUT_EN
    ep2_port_demux #(.TIMEOUT_CYCLES(10)) dut (
`else
    ep2_port_demux dut (
`endif
        .clk                    (clk),
        .reset                  (reset),
        .bus                    (bus),
        .write_fifo_byte_counts (counts),
        .pkt_active             (pkt_active),
        .cur_port               (cur_port),
        .err_count              (err_count),
        .err_pulse              (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the stream inputs and move to the falling edge for sampling.
    task automatic put(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        #4;
    endtask

    // Offer one byte, check the strobe (and data when a write is expected), clock it in.
    task automatic byte_in(input string tag, input logic [7:0] b, input logic [3:0] exp_wr);
        put(1'b1, b);
        chk({tag, "_wr"}, 128'(bus.fifo_write), 128'(exp_wr));
        if (exp_wr != 4'b0000) begin
            chk({tag, "_data"}, 128'(bus.fifo_data), 128'(b));
        end
        tick();
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.fifo_full = 4'b0000;

        // Reset state
        #2;
        chk("rst_counts", counts, 128'd0);
        chk("rst_pkt_active", 128'(pkt_active), 128'd0);
        chk("rst_cur_port", 128'(cur_port), 128'd0);
        chk("rst_err_count", 128'(err_count), 128'd0);
        chk("rst_err_pulse", 128'(err_pulse), 128'd0);
        chk("rst_fifo_write", 128'(bus.fifo_write), 128'd0);
        chk("rst_fifo_data", 128'(bus.fifo_data), 128'd0);
        tick();
        tick();
        reset = 1'b1;
        put(1'b0, 8'h00);
        chk("rel_in_ready", 128'(bus.in_ready), 128'd1);
        tick();

        // A2 00 03 11 22 33 -> three writes to port 2
        byte_in("p2_hdr", 8'hA2, 4'b0000);
        put(1'b1, 8'h00);
        chk("p2_pkt_active", 128'(pkt_active), 128'd1);
        chk("p2_cur_port", 128'(cur_port), 128'd2);
        tick();
        byte_in("p2_lenlo", 8'h03, 4'b0000);
        byte_in("p2_b0", 8'h11, 4'b0100);
        byte_in("p2_b1", 8'h22, 4'b0100);
        byte_in("p2_b2", 8'h33, 4'b0100);
        put(1'b0, 8'h00);
        chk("p2_done_wr", 128'(bus.fifo_write), 128'd0);
        chk("p2_done_active", 128'(pkt_active), 128'd0);
        chk("p2_counts", counts, {32'd0, 32'd3, 32'd0, 32'd0});
        tick();

        // Bad header 5F then A0 00 01 77
        byte_in("bad_hdr", 8'h5F, 4'b0000);
        put(1'b1, 8'hA0);
        chk("bad_err_pulse", 128'(err_pulse), 128'd1);
        chk("bad_err_count", 128'(err_count), 128'd1);
        chk("bad_pkt_active", 128'(pkt_active), 128'd0);
        tick();
        put(1'b1, 8'h00);
        chk("bad_pulse_once", 128'(err_pulse), 128'd0);
        tick();
        byte_in("p0_lenlo", 8'h01, 4'b0000);
        byte_in("p0_b0", 8'h77, 4'b0001);
        put(1'b0, 8'h00);
        chk("p0_counts", counts, {32'd0, 32'd3, 32'd0, 32'd1});
        chk("p0_err_count", 128'(err_count), 128'd1);
        tick();

        // Empty packet to port 1, then A3 00 01 EE back-to-back
        byte_in("e1_hdr", 8'hA1, 4'b0000);
        byte_in("e1_lenhi", 8'h00, 4'b0000);
        byte_in("e1_lenlo", 8'h00, 4'b0000);
        put(1'b1, 8'hA3);
        chk("e1_idle_after", 128'(pkt_active), 128'd0);
        chk("e1_hdr3_ready", 128'(bus.in_ready), 128'd1);
        tick();
        byte_in("p3_lenhi", 8'h00, 4'b0000);
        byte_in("p3_lenlo", 8'h01, 4'b0000);
        byte_in("p3_b0", 8'hEE, 4'b1000);
        put(1'b0, 8'h00);
        chk("p3_counts", counts, {32'd1, 32'd3, 32'd0, 32'd1});
        chk("p3_cur_port", 128'(cur_port), 128'd3);
        tick();

        // Backpressure on port 0 during the 2nd payload byte; port 1 full toggles
        byte_in("bp_hdr", 8'hA0, 4'b0000);
        byte_in("bp_lenhi", 8'h00, 4'b0000);
        byte_in("bp_lenlo", 8'h04, 4'b0000);
        byte_in("bp_b0", 8'h10, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            bus.fifo_full = (i % 2 == 0) ? 4'b0011 : 4'b0001;
            put(1'b1, 8'h20);
            chk("bp_stall_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_stall_wr", 128'(bus.fifo_write), 128'd0);
            chk("bp_stall_active", 128'(pkt_active), 128'd1);
            tick();
        end
        bus.fifo_full = 4'b0010;
        byte_in("bp_b1", 8'h20, 4'b0001);
        byte_in("bp_b2", 8'h30, 4'b0001);
        bus.fifo_full = 4'b0000;
        byte_in("bp_b3", 8'h40, 4'b0001);
        put(1'b0, 8'h00);
        chk("bp_counts", counts, {32'd1, 32'd3, 32'd0, 32'd5});
        chk("bp_done_active", 128'(pkt_active), 128'd0);
        tick();

        // Port 2 counter wrap from 0xFFFFFFFF
        force dut.g_port[2].cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.g_port[2].cnt_q;
        put(1'b0, 8'h00);
        chk("wrap_preload", counts, {32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5});
        tick();
        byte_in("wrap_hdr", 8'hA2, 4'b0000);
        byte_in("wrap_lenhi", 8'h00, 4'b0000);
        byte_in("wrap_lenlo", 8'h01, 4'b0000);
        byte_in("wrap_b0", 8'h00, 4'b0100);
        put(1'b0, 8'h00);
        chk("wrap_counts", counts, {32'd1, 32'd0, 32'd0, 32'd5});
        tick();

        // Reset mid-packet: A1 00 05 AA, then reset
        byte_in("mr_hdr", 8'hA1, 4'b0000);
        byte_in("mr_lenhi", 8'h00, 4'b0000);
        byte_in("mr_lenlo", 8'h05, 4'b0000);
        byte_in("mr_b0", 8'hAA, 4'b0010);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAB;
        reset = 1'b0;
        #1;
        chk("mr_counts", counts, 128'd0);
        chk("mr_pkt_active", 128'(pkt_active), 128'd0);
        chk("mr_cur_port", 128'(cur_port), 128'd0);
        chk("mr_err_count", 128'(err_count), 128'd0);
        chk("mr_fifo_write", 128'(bus.fifo_write), 128'd0);
        chk("mr_fifo_data", 128'(bus.fifo_data), 128'd0);
        tick();
        reset = 1'b1;
        byte_in("mr2_hdr", 8'hA1, 4'b0000);
        byte_in("mr2_lenhi", 8'h00, 4'b0000);
        byte_in("mr2_lenlo", 8'h01, 4'b0000);
        byte_in("mr2_b0", 8'hBB, 4'b0010);
        put(1'b0, 8'h00);
        chk("mr2_counts", counts, {32'd0, 32'd0, 32'd1, 32'd0});
        chk("mr2_err_count", 128'(err_count), 128'd0);
        tick();

`ifdef DEMUX_TIMEOUT_EN
        // Stall abort after 10 idle cycles mid-payload
        byte_in("to_hdr", 8'hA0, 4'b0000);
        byte_in("to_lenhi", 8'h00, 4'b0000);
        byte_in("to_lenlo", 8'h02, 4'b0000);
        byte_in("to_b0", 8'h01, 4'b0001);
        for (int i = 0; i < 9; i++) begin
            put(1'b0, 8'h00);
            tick();
        end
        put(1'b0, 8'h00);
        chk("to_still_active", 128'(pkt_active), 128'd1);
        tick();
        put(1'b0, 8'h00);
        chk("to_aborted", 128'(pkt_active), 128'd0);
        chk("to_err_pulse", 128'(err_pulse), 128'd1);
        chk("to_err_count", 128'(err_count), 128'd1);
        chk("to_counts", counts, {32'd0, 32'd0, 32'd1, 32'd1});
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ep2_port_demux.md
Name: ep2_port_demux

Overview:
- Upstream neighbour of the memory arbitrator's write side.
- Parses the EP2 host byte stream into packets and routes each payload byte into one of four per-port write FIFOs, selected by the port number in the packet header.
- Maintains the per-port cumulative byte counts that the arbitrator latches as write_fifo_byte_counts.

Parameters:
- NUM_PORTS, 4, number of destination write FIFOs; must be 4 (2-bit port field).
- SYNC_NIBBLE, 4'hA, required value of header bits [7:4].
- COUNT_WIDTH, 32, width of each per-port byte counter.
- TIMEOUT_CYCLES, 65535, idle-input abort threshold (used only with DEMUX_TIMEOUT_EN).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- in_data  input  8  EP2 stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- fifo_data  output  8  byte to the selected write FIFO.
- fifo_write  output  4  one-hot write strobe, bit n = port n.
- fifo_full  input  4  per-port FIFO full flag.
- write_fifo_byte_counts  output  128  4 x 32-bit payload byte counts, port n at [32n+31:32n].
- pkt_active  output  1  high while in LEN_HI, LEN_LO or PAYLOAD.
- cur_port  output  2  port of the current or last packet.
- err_count  output  8  saturating count of rejected header bytes and aborts.
- err_pulse  output  1  one-cycle pulse per error event.

Behaviour:
- Byte transfer occurs when in_valid && in_ready on a clk edge.
- Packet format, in order:
  - header: [7:4] = SYNC_NIBBLE, [3:2] reserved and ignored, [1:0] = port.
  - LEN_HI, then LEN_LO: 16-bit payload length N, MSB first.
  - N payload bytes.
- States: IDLE, LEN_HI, LEN_LO, PAYLOAD.
  - IDLE: in_ready = 1. On transfer with a valid sync nibble, latch cur_port and go to LEN_HI. On a bad nibble, drop the byte, stay in IDLE, pulse err_pulse and increment err_count (saturating at 255).
  - LEN_HI: in_ready = 1. Latch remaining[15:8], go to LEN_LO.
  - LEN_LO: in_ready = 1. Latch remaining[7:0]. If the full 16-bit length = 0, go to IDLE (empty packet, no FIFO writes); else go to PAYLOAD.
  - PAYLOAD: in_ready = !fifo_full[cur_port], combinational.
    - fifo_write[cur_port] = in_valid && in_ready; fifo_data = in_data; zero latency, both combinational.
    - On each transfer: remaining decrements and byte_count[cur_port] increments.
    - On the transfer with remaining = 1, go to IDLE.
- fifo_write is 0 in every state other than PAYLOAD. Header and length bytes never reach a FIFO or the counters.
- Byte counters wrap modulo 2^32 (0xFFFFFFFF + 1 = 0). Non-selected counters hold.
- fifo_full rising mid-packet: in_ready drops the same cycle, no byte is lost, and state and remaining hold.
- fifo_full on non-selected ports has no effect.
- Back-to-back packets: the header of the next packet may be accepted the cycle after the last payload byte.
- Reset values (while reset = 0, asynchronously):
  - state IDLE, remaining 0, cur_port 0, counters 0, err_count 0.
  - err_pulse 0, pkt_active 0, fifo_write 0, fifo_data 0.
  - in_ready = 1 once reset releases.
- Reset asserted mid-packet discards the packet; after release, the next byte is parsed as a header.
- err_pulse and err_count are registered and update on the edge following the error.

Optional Feature:
- Macro: DEMUX_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs while pkt_active and no transfer occurs, and clears on any transfer.
  - Backpressure cycles in PAYLOAD (fifo_full high) do not count.
  - When the counter reaches TIMEOUT_CYCLES, the state goes to IDLE, err_pulse fires and err_count increments.
  - Bytes already written stay counted.
- Not defined: no counter is instantiated, and a stalled partial packet waits indefinitely.

Test Plan:
- Reset, then stream A2 00 03 11 22 33 -> fifo_write = 4'b0100 for exactly 3 cycles with data 11, 22, 33; counts[95:64] = 3, other counts 0; pkt_active low after the last byte.
- Bad header 5F, then A0 00 01 77 -> err_pulse once, err_count = 1; port 0 receives 77; counts[31:0] = 1.
- A1 00 00, then A3 00 01 EE back-to-back -> no write to port 1; port 3 receives EE; counts[127:96] = 1.
- A0 00 04 with fifo_full[0] high during the 2nd payload byte for 5 cycles -> in_ready low for those 5 cycles; all 4 bytes delivered in order; count = 4; toggling fifo_full[1] in the same window has no effect.
- Preload by sending 2^32 - 1 bytes to port 2 (or force), then send A2 00 01 00 -> counts[95:64] wraps to 0; other ports unchanged.
- Reset pulled low after A1 00 05 AA -> all outputs at reset values immediately; after release, A1 00 01 BB yields port 1 count = 1 (AA discarded with the counter reset).
- With DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES = 10: A0 00 02 01, then in_valid low for 10 cycles -> state IDLE, err_count = 1, port 0 count = 1.
